// File: rtl/sweep_pattern_checker.sv
// ---------------------------------------------------------------------------
// sweep_pattern_checker
//
// Receive-side checker for the 8-bit one-hot LED sweep pattern:
//   0x01 held for DWELL samples, 0x02 .. 0x80 rising, 0x40 .. 0x01 falling,
//   then the dwell again.
// The checker decodes the position and direction of the sweep. It locks onto
// a legal sweep, counts completed sweeps, and flags and counts violations.
//
// Parameters:
//   DWELL  exact number of consecutive 0x01 samples between sweeps (1..15)
//   CNT_W  width of sweep_cnt
//   ERR_W  width of err_cnt
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high reset
//   pattern    in   sampled LED pattern
//   valid      in   pattern is sampled this cycle
//   pos        out  bit index of the last one-hot sample
//   dir        out  0 = rising/hunting, 1 = falling/dwelling
//   locked     out  tracking a legal sweep
//   err        out  one-cycle violation pulse
//   err_code   out  cause of the last error (01 not one-hot, 10 bad step,
//                   11 bad dwell length)
//   sweep_cnt  out  completed sweeps, wraps
//   err_cnt    out  violations, saturates
//   irq        out  sticky error interrupt
//   irq_clr    in   clears irq
//
// Build option: SWEEP_CHECK_IRQ_EN builds the sticky irq register. Without
// it, irq is tied to 0 and irq_clr is ignored.
// ---------------------------------------------------------------------------
module sweep_pattern_checker #(
    parameter int unsigned DWELL = 6,
    parameter int unsigned CNT_W = 8,
    parameter int unsigned ERR_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       pattern,
    input  logic             valid,
    output logic [2:0]       pos,
    output logic             dir,
    output logic             locked,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] sweep_cnt,
    output logic [ERR_W-1:0] err_cnt,
    output logic             irq,
    input  logic             irq_clr
);

    localparam logic [3:0] DWELL_LEN      = 4'(DWELL);
    localparam logic [1:0] CODE_NOT_ONEHOT = 2'b01;
    localparam logic [1:0] CODE_BAD_STEP   = 2'b10;
    localparam logic [1:0] CODE_BAD_DWELL  = 2'b11;

    typedef enum logic [1:0] {
        ST_HUNT  = 2'd0,
        ST_RISE  = 2'd1,
        ST_FALL  = 2'd2,
        ST_DWELL = 2'd3
    } state_t;

    // True when exactly one bit of v is set.
    function automatic logic f_is_onehot(input logic [7:0] v);
        return (v != 8'h00) && ((v & (v - 8'h01)) == 8'h00);
    endfunction

    // Index of the highest set bit (only meaningful for one-hot input).
    function automatic logic [2:0] f_bit_index(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

    state_t           r_state;
    logic [3:0]       r_dwell_cnt;
    logic [2:0]       r_pos;
    logic             r_dir;
    logic             r_locked;
    logic             r_err;
    logic [1:0]       r_err_code;
    logic [CNT_W-1:0] r_sweep_cnt;
    logic [ERR_W-1:0] r_err_cnt;

    state_t           w_state_nxt;
    logic [3:0]       w_dwell_nxt;
    logic [2:0]       w_pos_nxt;
    logic             w_dir_nxt;
    logic             w_locked_nxt;
    logic             w_err_nxt;
    logic [1:0]       w_code_nxt;
    logic [CNT_W-1:0] w_sweep_nxt;
    logic [ERR_W-1:0] w_errcnt_nxt;
    logic             w_fault;
    logic [1:0]       w_fault_code;

    logic             w_is_onehot;
    logic [2:0]       w_idx;
    logic             w_step_up;
    logic             w_step_dn;

    assign w_is_onehot = f_is_onehot(pattern);
    assign w_idx       = f_bit_index(pattern);
    // Guards on the end positions keep the 3-bit +/-1 from wrapping into a
    // false match (0x80 -> 0x01 or 0x01 -> 0x80).
    assign w_step_up   = w_is_onehot && (r_pos != 3'd7) && (w_idx == (r_pos + 3'd1));
    assign w_step_dn   = w_is_onehot && (r_pos != 3'd0) && (w_idx == (r_pos - 3'd1));

    // Next-state and next-output decode for one sampled pattern.
    always_comb begin
        w_state_nxt  = r_state;
        w_dwell_nxt  = r_dwell_cnt;
        w_pos_nxt    = r_pos;
        w_dir_nxt    = r_dir;
        w_locked_nxt = r_locked;
        w_err_nxt    = 1'b0;
        w_code_nxt   = r_err_code;
        w_sweep_nxt  = r_sweep_cnt;
        w_errcnt_nxt = r_err_cnt;
        w_fault      = 1'b0;
        w_fault_code = 2'b00;

        if (valid) begin
            if (w_is_onehot) begin
                w_pos_nxt = w_idx;
            end else begin
                w_pos_nxt = r_pos;
            end

            case (r_state)
                ST_HUNT: begin
                    // A single 0x01 is enough to arm; dwell length is only
                    // enforced once the checker has seen a full sweep.
                    if (pattern == 8'h01) begin
                        w_dwell_nxt = 4'd1;
                    end else if ((pattern == 8'h02) && (r_dwell_cnt != 4'd0)) begin
                        w_state_nxt  = ST_RISE;
                        w_locked_nxt = 1'b1;
                        w_dir_nxt    = 1'b0;
                        w_dwell_nxt  = 4'd0;
                    end else begin
                        w_dwell_nxt = 4'd0;
                    end
                end
                ST_RISE: begin
                    if (!w_is_onehot) begin
                        w_fault      = 1'b1;
                        w_fault_code = CODE_NOT_ONEHOT;
                    end else if (w_step_up) begin
                        if (w_idx == 3'd7) begin
                            w_state_nxt = ST_FALL;
                            w_dir_nxt   = 1'b1;
                        end else begin
                            w_state_nxt = ST_RISE;
                        end
                    end else begin
                        w_fault      = 1'b1;
                        w_fault_code = CODE_BAD_STEP;
                    end
                end
                ST_FALL: begin
                    if (!w_is_onehot) begin
                        w_fault      = 1'b1;
                        w_fault_code = CODE_NOT_ONEHOT;
                    end else if (w_step_dn) begin
                        if (w_idx == 3'd0) begin
                            // The 0x01 that ends the fall is the first dwell sample.
                            w_state_nxt = ST_DWELL;
                            w_dwell_nxt = 4'd1;
                        end else begin
                            w_state_nxt = ST_FALL;
                        end
                    end else begin
                        w_fault      = 1'b1;
                        w_fault_code = CODE_BAD_STEP;
                    end
                end
                ST_DWELL: begin
                    if (!w_is_onehot) begin
                        w_fault      = 1'b1;
                        w_fault_code = CODE_NOT_ONEHOT;
                    end else if (pattern == 8'h01) begin
                        if (r_dwell_cnt < DWELL_LEN) begin
                            w_dwell_nxt = r_dwell_cnt + 4'd1;
                        end else begin
                            w_fault      = 1'b1;
                            w_fault_code = CODE_BAD_DWELL;
                        end
                    end else if (pattern == 8'h02) begin
                        if (r_dwell_cnt == DWELL_LEN) begin
                            w_state_nxt = ST_RISE;
                            w_dir_nxt   = 1'b0;
                            w_dwell_nxt = 4'd0;
                            w_sweep_nxt = r_sweep_cnt + CNT_W'(1);
                        end else begin
                            w_fault      = 1'b1;
                            w_fault_code = CODE_BAD_DWELL;
                        end
                    end else begin
                        w_fault      = 1'b1;
                        w_fault_code = CODE_BAD_STEP;
                    end
                end
                default: begin
                    w_state_nxt  = ST_HUNT;
                    w_locked_nxt = 1'b0;
                    w_dir_nxt    = 1'b0;
                    w_dwell_nxt  = 4'd0;
                end
            endcase

            if (w_fault) begin
                w_state_nxt  = ST_HUNT;
                w_locked_nxt = 1'b0;
                w_dir_nxt    = 1'b0;
                w_err_nxt    = 1'b1;
                w_code_nxt   = w_fault_code;
                // An erroring 0x01 can itself serve as the arming sample.
                w_dwell_nxt  = (pattern == 8'h01) ? 4'd1 : 4'd0;
                if (r_err_cnt == {ERR_W{1'b1}}) begin
                    w_errcnt_nxt = r_err_cnt;
                end else begin
                    w_errcnt_nxt = r_err_cnt + ERR_W'(1);
                end
            end else begin
                w_err_nxt = 1'b0;
            end
        end else begin
            w_err_nxt = 1'b0;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_HUNT;
            r_dwell_cnt <= 4'd0;
            r_pos       <= 3'd0;
            r_dir       <= 1'b0;
            r_locked    <= 1'b0;
            r_err       <= 1'b0;
            r_err_code  <= 2'b00;
            r_sweep_cnt <= {CNT_W{1'b0}};
            r_err_cnt   <= {ERR_W{1'b0}};
        end else begin
            r_state     <= w_state_nxt;
            r_dwell_cnt <= w_dwell_nxt;
            r_pos       <= w_pos_nxt;
            r_dir       <= w_dir_nxt;
            r_locked    <= w_locked_nxt;
            r_err       <= w_err_nxt;
            r_err_code  <= w_code_nxt;
            r_sweep_cnt <= w_sweep_nxt;
            r_err_cnt   <= w_errcnt_nxt;
        end
    end

    assign pos       = r_pos;
    assign dir       = r_dir;
    assign locked    = r_locked;
    assign err       = r_err;
    assign err_code  = r_err_code;
    assign sweep_cnt = r_sweep_cnt;
    assign err_cnt   = r_err_cnt;

`ifdef SWEEP_CHECK_IRQ_EN
    logic r_irq;

    // Sticky interrupt: set by the err pulse, which beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_irq <= 1'b0;
        end else if (r_err) begin
            r_irq <= 1'b1;
        end else if (irq_clr) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= r_irq;
        end
    end

    assign irq = r_irq;
`else
    logic w_unused_irq_clr;

    assign w_unused_irq_clr = irq_clr;
    assign irq              = 1'b0;
`endif

endmodule

// File: tb/tb_sweep_pattern_checker.sv
module tb_sweep_pattern_checker;

    localparam int DWELL = 6;
    localparam int SEQ_L = 13 + DWELL;   // legal samples expected after locking on 0x02

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] pattern;
    logic       valid;
    logic       irq_clr;
    logic [2:0] pos;
    logic       dir;
    logic       locked;
    logic       err;
    logic [1:0] err_code;
    logic [7:0] sweep_cnt;
    logic [3:0] err_cnt;
    logic       irq;

    always #5 clk = ~clk;

    sweep_pattern_checker #(.DWELL(DWELL), .CNT_W(8), .ERR_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .pattern   (pattern),
        .valid     (valid),
        .pos       (pos),
        .dir       (dir),
        .locked    (locked),
        .err       (err),
        .err_code  (err_code),
        .sweep_cnt (sweep_cnt),
        .err_cnt   (err_cnt),
        .irq       (irq),
        .irq_clr   (irq_clr)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: the legal sweep seen as a cyclic list of expected values.
    logic [7:0] seq [SEQ_L];
    bit         m_locked;
    bit         m_has01;
    int         m_k;
    logic [2:0] m_pos;
    bit         m_err;
    logic [1:0] m_code;
    logic [7:0] m_sweep;
    int         m_errcnt;
    bit         m_irq;

    typedef struct {
        logic [7:0] pat;
        logic       vld;
        logic [2:0] pos;
        logic       dir;
        logic       locked;
        logic       err;
        logic [1:0] code;
        logic [7:0] sweep;
        logic [3:0] errcnt;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    function automatic int bit_pos(input logic [7:0] v);
        int p;
        p = 0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) p = i;
        end
        return p;
    endfunction

    task automatic model_update(input logic [7:0] p, input logic v, input logic clr, input logic rst);
        logic [7:0] expv;
        bit         oh;
        if (rst) begin
            m_locked = 0; m_has01 = 0; m_k = 0; m_pos = 3'd0; m_err = 0;
            m_code = 2'd0; m_sweep = 8'd0; m_errcnt = 0; m_irq = 0;
            return;
        end
`ifdef SWEEP_CHECK_IRQ_EN
        if (m_err) m_irq = 1;
        else if (clr) m_irq = 0;
`else
        m_irq = 0;
`endif
        m_err = 0;
        if (!v) return;
        oh = ($countones(p) == 1);
        if (oh) m_pos = 3'(bit_pos(p));
        if (!m_locked) begin
            if (p == 8'h02 && m_has01) begin
                m_locked = 1; m_k = 0;
            end
            m_has01 = (p == 8'h01);
        end else begin
            expv = seq[m_k];
            if (p == expv) begin
                m_k++;
                if (m_k == SEQ_L) begin
                    m_k = 0;
                    m_sweep = m_sweep + 8'd1;
                end
            end else begin
                m_err = 1;
                if (!oh) m_code = 2'b01;
                else if (m_k >= 13 && (p == 8'h01 || p == 8'h02)) m_code = 2'b11;
                else m_code = 2'b10;
                if (m_errcnt < 15) m_errcnt++;
                m_locked = 0;
                m_has01 = (p == 8'h01);
            end
        end
    endtask

    task automatic compare_model();
        check("pos", 32'(pos), 32'(m_pos));
        check("dir", 32'(dir), 32'(m_locked && m_k >= 6));
        check("locked", 32'(locked), 32'(m_locked));
        check("err", 32'(err), 32'(m_err));
        check("err_code", 32'(err_code), 32'(m_code));
        check("sweep_cnt", 32'(sweep_cnt), 32'(m_sweep));
        check("err_cnt", 32'(err_cnt), 32'(m_errcnt));
        check("irq", 32'(irq), 32'(m_irq));
    endtask

    task automatic step(input logic [7:0] p, input logic v, input logic clr, input logic rst);
        pattern = p; valid = v; irq_clr = clr; reset = rst;
        @(posedge clk);
        model_update(p, v, clr, rst);
        #1;
        compare_model();
    endtask

    function automatic void add(input logic [7:0] p, input logic v, input int ps, input logic d,
                                input logic lk, input logic e, input logic [1:0] c,
                                input int sw, input int ec);
        vec_t t;
        t.pat = p; t.vld = v; t.pos = 3'(ps); t.dir = d; t.locked = lk; t.err = e;
        t.code = c; t.sweep = 8'(sw); t.errcnt = 4'(ec);
        vecs.push_back(t);
    endfunction

    // Rise from 0x04 through 0x80, then fall down to 0x02.
    task automatic sweep_body();
        for (int i = 2; i <= 7; i++) step(8'(1 << i), 1'b1, 1'b0, 1'b0);
        for (int i = 6; i >= 1; i--) step(8'(1 << i), 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] gen_cycle [DWELL + 13];
        int         g;
        int         r;
        logic [7:0] p;
        logic       v;

        for (int i = 0; i < 6; i++) seq[i] = 8'(1 << (i + 2));
        for (int i = 0; i < 7; i++) seq[6 + i] = 8'(1 << (6 - i));
        for (int i = 0; i < DWELL - 1; i++) seq[13 + i] = 8'h01;
        seq[SEQ_L - 1] = 8'h02;

        // Directed table: legal sweep, not-one-hot, illegal step, relock, valid gaps.
        for (int i = 0; i < 6; i++) add(8'h01, 1, 0, 0, 0, 0, 0, 0, 0);
        add(8'h02, 1, 1, 0, 1, 0, 0, 0, 0);
        for (int i = 2; i <= 7; i++) add(8'(1 << i), 1, i, (i == 7), 1, 0, 0, 0, 0);
        for (int i = 6; i >= 0; i--) add(8'(1 << i), 1, i, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) add(8'h01, 1, 0, 1, 1, 0, 0, 0, 0);
        add(8'h02, 1, 1, 0, 1, 0, 0, 1, 0);
        add(8'h04, 1, 2, 0, 1, 0, 0, 1, 0);
        add(8'h08, 1, 3, 0, 1, 0, 0, 1, 0);
        add(8'h18, 1, 3, 0, 0, 1, 2'b01, 1, 1);
        add(8'h01, 1, 0, 0, 0, 0, 2'b01, 1, 1);
        add(8'h02, 1, 1, 0, 1, 0, 2'b01, 1, 1);
        add(8'h04, 1, 2, 0, 1, 0, 2'b01, 1, 1);
        add(8'h10, 1, 4, 0, 0, 1, 2'b10, 1, 2);
        add(8'h01, 1, 0, 0, 0, 0, 2'b10, 1, 2);
        add(8'h02, 1, 1, 0, 1, 0, 2'b10, 1, 2);
        add(8'h04, 1, 2, 0, 1, 0, 2'b10, 1, 2);
        for (int i = 0; i < 3; i++) add(8'hFF, 0, 2, 0, 1, 0, 2'b10, 1, 2);
        add(8'h08, 1, 3, 0, 1, 0, 2'b10, 1, 2);

        pattern = 8'h00; valid = 1'b0; irq_clr = 1'b0; reset = 1'b1;
        step(8'h00, 1'b0, 1'b0, 1'b1);
        check("reset_pos", 32'(pos), 32'd0);
        check("reset_locked", 32'(locked), 32'd0);
        check("reset_err_cnt", 32'(err_cnt), 32'd0);

        foreach (vecs[i]) begin
            step(vecs[i].pat, vecs[i].vld, 1'b0, 1'b0);
            check("tbl_pos", 32'(pos), 32'(vecs[i].pos));
            check("tbl_dir", 32'(dir), 32'(vecs[i].dir));
            check("tbl_locked", 32'(locked), 32'(vecs[i].locked));
            check("tbl_err", 32'(err), 32'(vecs[i].err));
            check("tbl_err_code", 32'(err_code), 32'(vecs[i].code));
            check("tbl_sweep_cnt", 32'(sweep_cnt), 32'(vecs[i].sweep));
            check("tbl_err_cnt", 32'(err_cnt), 32'(vecs[i].errcnt));
        end

        // Short dwell: rising at 0x08, finish the sweep, then 0x01 x4 and 0x02.
        for (int i = 4; i <= 7; i++) step(8'(1 << i), 1'b1, 1'b0, 1'b0);
        for (int i = 6; i >= 1; i--) step(8'(1 << i), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(8'h01, 1'b1, 1'b0, 1'b0);
        step(8'h02, 1'b1, 1'b0, 1'b0);
        check("short_dwell_err", 32'(err), 32'd1);
        check("short_dwell_code", 32'(err_code), 32'd3);

        // Long dwell: relock, full sweep, then 0x01 x7; error on the 7th only.
        step(8'h01, 1'b1, 1'b0, 1'b0);
        step(8'h02, 1'b1, 1'b0, 1'b0);
        sweep_body();
        for (int i = 0; i < 6; i++) step(8'h01, 1'b1, 1'b0, 1'b0);
        check("long_dwell_no_err_6th", 32'(err), 32'd0);
        step(8'h01, 1'b1, 1'b0, 1'b0);
        check("long_dwell_err", 32'(err), 32'd1);
        check("long_dwell_code", 32'(err_code), 32'd3);

        // Erroring 0x01 arms the hunt, so 0x02 relocks; reset during the fall.
        step(8'h02, 1'b1, 1'b0, 1'b0);
        check("relock_after_01_err", 32'(locked), 32'd1);
        for (int i = 2; i <= 7; i++) step(8'(1 << i), 1'b1, 1'b0, 1'b0);
        step(8'h40, 1'b1, 1'b0, 1'b0);
        step(8'h20, 1'b1, 1'b0, 1'b0);
        check("pre_reset_dir", 32'(dir), 32'd1);
        step(8'h10, 1'b1, 1'b0, 1'b1);
        check("midfall_reset_pos", 32'(pos), 32'd0);
        check("midfall_reset_dir", 32'(dir), 32'd0);
        check("midfall_reset_locked", 32'(locked), 32'd0);
        check("midfall_reset_code", 32'(err_code), 32'd0);
        step(8'h08, 1'b1, 1'b0, 1'b0);
        check("post_reset_hunting", 32'(locked), 32'd0);
        check("post_reset_no_err", 32'(err), 32'd0);

        // 16 errors: err_cnt saturates at 15.
        for (int i = 0; i < 16; i++) begin
            step(8'h01, 1'b1, 1'b0, 1'b0);
            step(8'h02, 1'b1, 1'b0, 1'b0);
            step(8'h03, 1'b1, 1'b0, 1'b0);
            check("sat_err_cnt", 32'(err_cnt), 32'((i + 1 > 15) ? 15 : i + 1));
        end
        step(8'h01, 1'b1, 1'b0, 1'b0);
`ifdef SWEEP_CHECK_IRQ_EN
        check("irq_set", 32'(irq), 32'd1);
        step(8'h01, 1'b1, 1'b1, 1'b0);
        check("irq_cleared", 32'(irq), 32'd0);
        step(8'h02, 1'b1, 1'b0, 1'b0);
        step(8'h03, 1'b1, 1'b0, 1'b0);
        step(8'h01, 1'b1, 1'b1, 1'b0);
        check("irq_err_beats_clr", 32'(irq), 32'd1);
`else
        check("irq_off", 32'(irq), 32'd0);
        step(8'h01, 1'b1, 1'b1, 1'b0);
        check("irq_off_clr", 32'(irq), 32'd0);
`endif
        step(8'h00, 1'b0, 1'b0, 1'b1);

        // Random: mostly legal sweeps with occasional corruption, gaps, clears, resets.
        for (int i = 0; i < DWELL; i++) gen_cycle[i] = 8'h01;
        for (int i = 1; i <= 7; i++) gen_cycle[DWELL + i - 1] = 8'(1 << i);
        for (int i = 6; i >= 1; i--) gen_cycle[DWELL + 13 - i] = 8'(1 << i);
        g = 0;
        for (int n = 0; n < 4000; n++) begin
            r = $urandom_range(0, 999);
            v = ($urandom_range(0, 7) != 0);
            p = gen_cycle[g];
            if (r < 15) p = 8'($urandom_range(0, 255));
            else if (r < 30) p = 8'(1 << $urandom_range(0, 7));
            else if (r < 40) g = (g + DWELL + 12) % (DWELL + 13);   // repeat previous value
            else if (r < 50) begin
                g = (g + 1) % (DWELL + 13);                          // skip one value
                p = gen_cycle[g];
            end
            if (v) g = (g + 1) % (DWELL + 13);
            step(p, v, ($urandom_range(0, 15) == 0), ($urandom_range(0, 499) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
